spi_sclk_gen: RTL and testbench



---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_prescale_tick.sv | 29 ++
 rtl/spi_sclk_gen.sv | 137 +++++++++++++
 tb/tb_spi_sclk_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock generator: FSM state encoding
// and default widths.
package spi_pkg;

    localparam int PRE_W_DEF = 8;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

endpackage

// File: rtl/spi_prescale_tick.sv
// Prescaler: counts 0..CPre while enabled and flags the wrap with a
// single-cycle Tick, giving one tick every CPre+1 cycles.
module spi_prescale_tick #(
    parameter int PRE_W = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Clr,
    input  logic             En,
    input  logic [PRE_W-1:0] CPre,
    output logic             Tick
);

    logic [PRE_W-1:0] cnt;

    // Combinational so the caller can register its reaction on the wrap edge.
    assign Tick = En && (cnt == CPre);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (Clr) begin
            cnt <= '0;
        end else if (En) begin
            cnt <= Tick ? '0 : cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: runs NBits SCLK periods in the selected
// CPOL/CPHA mode, with Start/Busy/Done handshake and Sample/Shift strobes.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [PRE_W-1:0] CPre,
    input  logic [CNT_W-1:0] NBits,
    input  logic             Cpol,
    input  logic             Cpha,
    output logic             Busy,
    output logic             Sclk,
    output logic             Sample,
    output logic             Shift,
    output logic             Done
);

    state_t           state, state_nxt;
    logic [PRE_W-1:0] cpre_l;
    logic [CNT_W-1:0] nbits_l;
    logic             cpol_l, cpha_l;
    logic [CNT_W:0]   edge_cnt, edge_nxt, edge_inc;
    logic             zero_pend, zero_pend_nxt;
    logic             busy_nxt, sclk_nxt, sample_nxt, shift_nxt, done_nxt;
    logic             accept, tick, sample_sel;

    // A Start coinciding with Done, or with a pending zero-length Done, is ignored.
    assign accept = (state == ST_IDLE) && Start && !Done && !zero_pend;

    spi_prescale_tick #(
        .PRE_W (PRE_W)
    ) u_prescale (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Clr   (accept),
        .En    (state != ST_IDLE),
        .CPre  (cpre_l),
        .Tick  (tick)
    );

    assign edge_inc   = edge_cnt + (CNT_W + 1)'(1);
    // Odd edge numbers are leading edges; CPHA picks which of the two samples.
    assign sample_sel = edge_inc[0] ^ cpha_l;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cpre_l  <= '0;
            nbits_l <= '0;
            cpol_l  <= 1'b0;
            cpha_l  <= 1'b0;
        end else if (accept) begin
            cpre_l  <= CPre;
            nbits_l <= NBits;
            cpol_l  <= Cpol;
            cpha_l  <= Cpha;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            edge_cnt  <= '0;
            zero_pend <= 1'b0;
            Busy      <= 1'b0;
            Sclk      <= 1'b0;
            Sample    <= 1'b0;
            Shift     <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            edge_cnt  <= edge_nxt;
            zero_pend <= zero_pend_nxt;
            Busy      <= busy_nxt;
            Sclk      <= sclk_nxt;
            Sample    <= sample_nxt;
            Shift     <= shift_nxt;
            Done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        edge_nxt      = edge_cnt;
        zero_pend_nxt = 1'b0;
        busy_nxt      = Busy;
        sclk_nxt      = Sclk;
        sample_nxt    = 1'b0;
        shift_nxt     = 1'b0;
        done_nxt      = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                done_nxt = zero_pend;
                if (accept) begin
                    sclk_nxt = Cpol;
                    edge_nxt = '0;
                    if (NBits != '0) begin
                        state_nxt = ST_RUN;
                        busy_nxt  = 1'b1;
                    end else begin
                        zero_pend_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (tick) begin
                    sclk_nxt   = ~Sclk;
                    edge_nxt   = edge_inc;
                    sample_nxt = sample_sel;
                    shift_nxt  = ~sample_sel;
                    if (edge_inc == {nbits_l, 1'b0}) begin
                        state_nxt = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                // Final half-period so the last SCLK level is held before Done.
                if (tick) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: per-cycle expected output vectors are
// queued when each burst is launched and popped after every clock edge.
module tb_spi_sclk_gen;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] CPre = '0;
    logic [5:0] NBits = '0;
    logic       Cpol = 1'b0;
    logic       Cpha = 1'b0;
    logic       Busy, Sclk, Sample, Shift, Done;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] sb[$];
    int         n_tog, n_smp, n_shf;
    logic       sclk_prev;

    spi_sclk_gen #(
        .PRE_W (8),
        .CNT_W (6)
    ) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Start  (Start),
        .CPre   (CPre),
        .NBits  (NBits),
        .Cpol   (Cpol),
        .Cpha   (Cpha),
        .Busy   (Busy),
        .Sclk   (Sclk),
        .Sample (Sample),
        .Shift  (Shift),
        .Done   (Done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] obs();
        return {Busy, Sclk, Sample, Shift, Done};
    endfunction

    // Expected {Busy,Sclk,Sample,Shift,Done} after the k-th edge, edge 0 being the accepting edge.
    function automatic logic [4:0] exp_at(input int k, input int cpre, input int nbits,
                                          input logic cpol, input logic cpha);
        int   half, last, m;
        logic edg, lead;
        half = cpre + 1;
        if (nbits == 0) return {1'b0, cpol, 2'b00, (k == 1)};
        last = (2 * nbits + 1) * half;
        if (k >= last) return {1'b0, cpol, 2'b00, (k == last)};
        m    = k / half;
        edg  = (k % half == 0) && (m >= 1);
        lead = (m % 2 == 1);
        return {1'b1, cpol ^ lead, edg && (lead != cpha), edg && (lead == cpha), 1'b0};
    endfunction

    task automatic check_v(input string tag, input logic [4:0] got, input logic [4:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed={B,S,Sm,Sh,D}=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic check_i(input string tag, input int got, input int want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic step(input string tag, input int k);
        logic [4:0] e;
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check_v($sformatf("%s k=%0d", tag, k), obs(), e);
        if (Sclk !== sclk_prev) n_tog++;
        sclk_prev = Sclk;
        if (Sample) n_smp++;
        if (Shift)  n_shf++;
    endtask

    task automatic burst(input string tag, input int cpre, input int nbits, input logic cpol,
                         input logic cpha, input bit hold, input bit chg);
        int n, k;
        n = (nbits == 0) ? 3 : (2 * nbits + 1) * (cpre + 1) + 2;
        for (int i = 0; i < n; i++) sb.push_back(exp_at(i, cpre, nbits, cpol, cpha));
        CPre  = 8'(cpre);
        NBits = 6'(nbits);
        Cpol  = cpol;
        Cpha  = cpha;
        Start = 1'b1;
        k = 0;
        while (sb.size() > 0) begin
            step(tag, k);
            if (k == 0) begin
                if (!hold) Start = 1'b0;
                n_tog = 0;
                n_smp = 0;
                n_shf = 0;
            end
            if (chg && k == 1) begin
                CPre  = 8'd5;
                NBits = 6'd9;
                Cpol  = 1'b1;
                Cpha  = 1'b1;
            end
            k++;
        end
        Start = 1'b0;
    endtask

    initial begin
        sclk_prev = 1'b0;
        #1;
        check_v("reset_async", obs(), 5'b00000);
        @(posedge Clk);
        #1;
        check_v("reset_held", obs(), 5'b00000);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check_v("idle_after_reset", obs(), 5'b00000);
        sclk_prev = Sclk;

        burst("mode0_cpre1_n2", 1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        burst("mode3_cpre0_n3", 0, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        burst("nbits0", 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        burst("mode1_cpre2_n1", 2, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        burst("mode2_cpre3_n2", 3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        // Start held through the Done cycle and config changed mid-burst: no effect.
        burst("midburst_changes", 1, 2, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge Clk);
        #1;
        check_v("start_in_done_cycle_ignored", obs(), 5'b00000);

        for (int i = 0; i <= 11; i++) sb.push_back(exp_at(i, 1, 2, 1'b0, 1'b0));
        CPre  = 8'd1;
        NBits = 6'd2;
        Cpol  = 1'b0;
        Cpha  = 1'b0;
        Start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step("pre_reset", k);
            Start = 1'b0;
        end
        #2;
        Rst_n = 1'b0;
        #1;
        check_v("reset_midburst_immediate", obs(), 5'b00000);
        sb.delete();
        repeat (2) @(posedge Clk);
        #1;
        check_v("reset_midburst_no_done", obs(), 5'b00000);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check_v("idle_after_release", obs(), 5'b00000);
        sclk_prev = Sclk;
        burst("after_reset_mode2", 2, 2, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int b = 0; b < 2; b++) begin
            burst($sformatf("b2b%0d", b), 255, 63, 1'b0, 1'b0, 1'b0, 1'b0);
            check_i($sformatf("b2b%0d_sclk_edges", b), n_tog, 126);
            check_i($sformatf("b2b%0d_samples", b), n_smp, 63);
            check_i($sformatf("b2b%0d_shifts", b), n_shf, 63);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
